// File: rtl/pwm_duty_slew_ctrl.sv
// PWM duty command stage: clamps CPU duty writes to the PWM period, slews the
// applied duty toward the target by at most STEP per PWM period, and forces the
// motor off through a command watchdog when the CPU stops writing.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   wr_en        one-cycle strobe, wr_data is a new target duty
//   wr_data      requested duty in clk counts (clamped to PERIOD)
//   clr_fault    one-cycle strobe, leaves FAULT
//   duty         applied duty to the PWM counter (registered)
//   enable       PWM enable to the PWM counter (registered)
//   period_tick  one-cycle pulse at the end of each PWM period
//   busy         high while ramping
//   fault        high while in FAULT
module pwm_duty_slew_ctrl #(
    parameter int unsigned PERIOD       = 500,
    parameter int unsigned STEP         = 25,
    parameter int unsigned WDOG_PERIODS = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        clr_fault,
    output logic [31:0] duty,
    output logic        enable,
    output logic        period_tick,
    output logic        busy,
    output logic        fault
);

    localparam int PW = (PERIOD < 2) ? 1 : $clog2(PERIOD + 1);
    localparam int WW = (WDOG_PERIODS < 2) ? 1 : $clog2(WDOG_PERIODS + 1);

    localparam logic [31:0]   PER32   = 32'(PERIOD);
    localparam logic [31:0]   STEP32  = 32'(STEP);
    localparam logic [PW-1:0] PER_TOP = PW'(PERIOD);
    localparam logic [WW-1:0] WD_LAST = WW'(WDOG_PERIODS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAMP,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t        state_q;
    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic [WW-1:0] wdog_q;
    logic [31:0]   target_q;
    logic [31:0]   duty_q;
    logic          enable_q;
    logic          tick_q;
    logic          busy_q;
    logic          fault_q;

    logic [31:0]   wr_clamp;
    logic [31:0]   slew_d;
    logic [31:0]   target_d;
    logic          wdog_expire;

    always_comb begin
        pcnt_d   = (pcnt_q == PER_TOP) ? '0 : pcnt_q + PW'(1);
        wr_clamp = (wr_data > PER32) ? PER32 : wr_data;
        target_d = wr_en ? wr_clamp : target_q;
        // Subtract only on the side that cannot underflow.
        slew_d   = duty_q;
        if (target_q >= duty_q) begin
            if ((target_q - duty_q) <= STEP32) slew_d = target_q;
            else                              slew_d = duty_q + STEP32;
        end else begin
            if ((duty_q - target_q) <= STEP32) slew_d = target_q;
            else                              slew_d = duty_q - STEP32;
        end
        // A write in the expiry cycle rescues the command stream.
        wdog_expire = tick_q && !wr_en && (wdog_q == WD_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pcnt_q   <= '0;
            wdog_q   <= '0;
            target_q <= '0;
            duty_q   <= '0;
            enable_q <= 1'b0;
            tick_q   <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            tick_q <= (pcnt_q == PER_TOP);
            unique case (state_q)
                S_IDLE: begin
                    duty_q <= '0;
                    wdog_q <= '0;
                    if (wr_en) begin
                        target_q <= wr_clamp;
                        if (wr_clamp != '0) begin
                            state_q  <= S_RAMP;
                            enable_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end
                    end
                end
                S_RAMP, S_HOLD: begin
                    if (wdog_expire) begin
                        state_q  <= S_FAULT;
                        duty_q   <= '0;
                        target_q <= '0;
                        wdog_q   <= '0;
                        enable_q <= 1'b0;
                        busy_q   <= 1'b0;
                        fault_q  <= 1'b1;
                    end else begin
                        target_q <= target_d;
                        if (wr_en)       wdog_q <= '0;
                        else if (tick_q) wdog_q <= wdog_q + WW'(1);
                        if (state_q == S_RAMP) begin
                            // Slew uses the pre-edge target; arrival is
                            // judged against the target after this edge.
                            if (tick_q) begin
                                duty_q <= slew_d;
                                if (slew_d == target_d) begin
                                    busy_q <= 1'b0;
                                    if (target_d == '0) begin
                                        state_q  <= S_IDLE;
                                        enable_q <= 1'b0;
                                        wdog_q   <= '0;
                                    end else begin
                                        state_q <= S_HOLD;
                                    end
                                end
                            end
                        end else if (wr_en && (wr_clamp != duty_q)) begin
                            state_q <= S_RAMP;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_FAULT: begin
                    duty_q   <= '0;
                    target_q <= '0;
                    wdog_q   <= '0;
                    if (clr_fault) begin
                        state_q <= S_IDLE;
                        fault_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign duty        = duty_q;
    assign enable      = enable_q;
    assign period_tick = tick_q;
    assign busy        = busy_q;
    assign fault       = fault_q;

endmodule
